// File: rtl/axis_wb_bridge.sv
// Byte-stream to Wishbone command bridge: CMD/ADDR/LEN[/DATA] frames in, read data + status byte out.
// Latency: bus cycle starts the cycle after the last request byte of a word; responses leave as registered bytes.
// Backpressure: input stalls while a bus cycle or response byte is pending; output bytes hold until o_axis_tready.
module axis_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_axis_tdata,
    input  logic                    i_axis_tvalid,
    output logic                    i_axis_tready,
    input  logic                    i_axis_tlast,
    output logic [7:0]              o_axis_tdata,
    output logic                    o_axis_tvalid,
    input  logic                    o_axis_tready,
    output logic                    o_axis_tlast,
    output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
    input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
    output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i,
    input  logic                    m_wb_err_i,
    output logic                    m_wb_cyc_o,
    output logic                    o_busy
);
    localparam int AB  = ADDR_WIDTH / 8;
    localparam int DB  = DATA_WIDTH / 8;
    localparam int DCW = $clog2(256 * DB) + 1;

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_LEN, S_WDATA, S_BUS, S_RDATA, S_STATUS, S_DRAIN
    } state_t;

    state_t                  state;
    logic                    rdy_en;
    logic                    is_write;
    logic                    is_fixed;
    logic                    drain_to_last;
    logic [7:0]              byte_cnt;
    logic [7:0]              words_left;
    logic [7:0]              status;
    logic [DCW-1:0]          drain_cnt;
    logic [DATA_WIDTH-1:0]   rdat;
    logic [15:0]             tmo;
    logic                    in_acc;
    logic                    out_acc;
    logic                    bad_cmd;
    logic                    bus_ack;
    logic                    bus_fail;
    logic [7:0]              fail_code;
    logic [ADDR_WIDTH-1:0]   next_addr;

    // rdy_en keeps tready low during reset and lets it rise on the first cycle after release
    assign i_axis_tready = rdy_en && (state inside {S_CMD, S_ADDR, S_LEN, S_WDATA, S_DRAIN});
    assign in_acc        = i_axis_tvalid && i_axis_tready;
    assign out_acc       = o_axis_tvalid && o_axis_tready;
    assign bad_cmd       = (i_axis_tdata[7:3] != 5'd0) || !(i_axis_tdata[1:0] inside {2'b01, 2'b10});
    // err has priority over ack; a timeout fires on the last allowed strobe cycle
    assign bus_ack       = m_wb_stb_o && m_wb_ack_i && !m_wb_err_i;
    assign bus_fail      = m_wb_stb_o && (m_wb_err_i || (!m_wb_ack_i && tmo == 16'(TIMEOUT - 1)));
    assign fail_code     = m_wb_err_i ? 8'h01 : 8'h02;
    assign next_addr     = is_fixed ? m_wb_adr_o : m_wb_adr_o + ADDR_WIDTH'(DB);
    assign m_wb_cyc_o    = m_wb_stb_o;
    assign m_wb_sel_o    = {DB{m_wb_stb_o}};
    assign o_busy        = (state != S_CMD);

    // Request parser, bus sequencer and response generator
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_CMD;
            rdy_en        <= 1'b0;
            is_write      <= 1'b0;
            is_fixed      <= 1'b0;
            drain_to_last <= 1'b0;
            byte_cnt      <= '0;
            words_left    <= '0;
            status        <= '0;
            drain_cnt     <= '0;
            rdat          <= '0;
            tmo           <= '0;
            o_axis_tdata  <= '0;
            o_axis_tvalid <= 1'b0;
            o_axis_tlast  <= 1'b0;
            m_wb_adr_o    <= '0;
            m_wb_dat_o    <= '0;
            m_wb_we_o     <= 1'b0;
            m_wb_stb_o    <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                S_CMD: if (in_acc) begin
                    is_write <= i_axis_tdata[1];
                    is_fixed <= i_axis_tdata[2];
                    byte_cnt <= '0;
                    if (!bad_cmd) begin
                        state <= S_ADDR;
                    end else if (i_axis_tlast) begin
                        o_axis_tdata  <= 8'h03;
                        o_axis_tvalid <= 1'b1;
                        o_axis_tlast  <= 1'b1;
                        state         <= S_STATUS;
                    end else begin
                        status        <= 8'h03;
                        drain_to_last <= 1'b1;
                        state         <= S_DRAIN;
                    end
                end
                S_ADDR: if (in_acc) begin
                    m_wb_adr_o <= ADDR_WIDTH'({m_wb_adr_o, i_axis_tdata});
                    byte_cnt   <= byte_cnt + 8'd1;
                    if (byte_cnt == 8'(AB - 1)) state <= S_LEN;
                end
                S_LEN: if (in_acc) begin
                    words_left <= i_axis_tdata;
                    byte_cnt   <= '0;
                    if (is_write) begin
                        state <= S_WDATA;
                    end else begin
                        m_wb_stb_o <= 1'b1;
                        tmo        <= '0;
                        state      <= S_BUS;
                    end
                end
                S_WDATA: if (in_acc) begin
                    m_wb_dat_o <= DATA_WIDTH'({m_wb_dat_o, i_axis_tdata});
                    byte_cnt   <= byte_cnt + 8'd1;
                    if (byte_cnt == 8'(DB - 1)) begin
                        byte_cnt   <= '0;
                        m_wb_stb_o <= 1'b1;
                        m_wb_we_o  <= 1'b1;
                        tmo        <= '0;
                        state      <= S_BUS;
                    end
                end
                S_BUS: begin
                    tmo <= tmo + 16'd1;
                    if (bus_ack) begin
                        m_wb_stb_o <= 1'b0;
                        m_wb_we_o  <= 1'b0;
                        if (!is_write) begin
                            rdat          <= m_wb_dat_i << 8;
                            o_axis_tdata  <= m_wb_dat_i[DATA_WIDTH-1 -: 8];
                            o_axis_tvalid <= 1'b1;
                            byte_cnt      <= '0;
                            state         <= S_RDATA;
                        end else if (words_left == 8'd0) begin
                            o_axis_tdata  <= 8'h00;
                            o_axis_tvalid <= 1'b1;
                            o_axis_tlast  <= 1'b1;
                            state         <= S_STATUS;
                        end else begin
                            words_left <= words_left - 8'd1;
                            m_wb_adr_o <= next_addr;
                            state      <= S_WDATA;
                        end
                    end else if (bus_fail) begin
                        m_wb_stb_o <= 1'b0;
                        m_wb_we_o  <= 1'b0;
                        if (is_write && words_left != 8'd0) begin
                            // remaining write words are still in flight on the link; swallow them by count
                            status        <= fail_code;
                            drain_to_last <= 1'b0;
                            drain_cnt     <= DCW'(words_left) * DCW'(DB);
                            state         <= S_DRAIN;
                        end else begin
                            o_axis_tdata  <= fail_code;
                            o_axis_tvalid <= 1'b1;
                            o_axis_tlast  <= 1'b1;
                            state         <= S_STATUS;
                        end
                    end
                end
                S_RDATA: if (out_acc) begin
                    if (byte_cnt != 8'(DB - 1)) begin
                        o_axis_tdata <= rdat[DATA_WIDTH-1 -: 8];
                        rdat         <= rdat << 8;
                        byte_cnt     <= byte_cnt + 8'd1;
                    end else if (words_left == 8'd0) begin
                        o_axis_tdata <= 8'h00;
                        o_axis_tlast <= 1'b1;
                        state        <= S_STATUS;
                    end else begin
                        o_axis_tvalid <= 1'b0;
                        words_left    <= words_left - 8'd1;
                        m_wb_adr_o    <= next_addr;
                        m_wb_stb_o    <= 1'b1;
                        tmo           <= '0;
                        state         <= S_BUS;
                    end
                end
                S_STATUS: if (out_acc) begin
                    o_axis_tdata  <= '0;
                    o_axis_tvalid <= 1'b0;
                    o_axis_tlast  <= 1'b0;
                    state         <= S_CMD;
                end
                S_DRAIN: if (in_acc) begin
                    if (drain_to_last ? i_axis_tlast : (drain_cnt == DCW'(1))) begin
                        o_axis_tdata  <= status;
                        o_axis_tvalid <= 1'b1;
                        o_axis_tlast  <= 1'b1;
                        state         <= S_STATUS;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                default: state <= S_CMD;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_wb_bridge.sv
// Bench for axis_wb_bridge: table of request frames with slave behaviour and expected status,
// a byte-level response scoreboard and a Wishbone op scoreboard, plus reset/timeout sequences.
module tb_axis_wb_bridge;
    logic        clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_tdata;
    logic        i_tvalid, i_tlast, i_axis_tready;
    logic [7:0]  o_tdata;
    logic        o_tvalid, o_tready, o_tlast;
    logic [31:0] adr, dat_i, dat_o;
    logic        we, stb, cyc, ack, err, busy;
    logic [3:0]  sel;

    always #5 clk = ~clk;

    axis_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_axis_tdata(i_tdata), .i_axis_tvalid(i_tvalid), .i_axis_tready(i_axis_tready), .i_axis_tlast(i_tlast),
        .o_axis_tdata(o_tdata), .o_axis_tvalid(o_tvalid), .o_axis_tready(o_tready), .o_axis_tlast(o_tlast),
        .m_wb_adr_o(adr), .m_wb_dat_i(dat_i), .m_wb_dat_o(dat_o), .m_wb_we_o(we), .m_wb_sel_o(sel),
        .m_wb_stb_o(stb), .m_wb_ack_i(ack), .m_wb_err_i(err), .m_wb_cyc_o(cyc), .o_busy(busy)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [7:0]  len;
        int          err_word;
        bit          err_both;
        bit          noack;
        int          ack_wait;
        int          tr_mode;
        int          junk;
        logic [7:0]  exp_status;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } wbop_t;

    int tests = 0, fails = 0;
    logic [8:0] exp_q[$];
    wbop_t      wb_q[$];
    wbop_t      op;
    vec_t       vt[14];

    int cur_vec = 0, err_word = -1, ack_wait = 0, tr_mode = 0;
    int cyc_idx = 0, wcnt = 0, stb_run = 0, last_run = 0, tr_cnt = 0;
    bit err_both = 0, noack = 0, wb_chk = 1, hold = 0;
    logic [8:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input int v, input int idx, input logic [31:0] a);
        return {8'(v), 8'(idx), a[15:0]};
    endfunction

    // Wishbone slave, response scoreboard and tready pattern, all evaluated away from the active edge
    always @(negedge clk) begin
        tr_cnt++;
        o_tready = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? (tr_cnt % 3 == 0) : 1'b0;
        ack = 1'b0;
        err = 1'b0;
        if (i_reset) begin
            hold    = 0;
            stb_run = 0;
        end else begin
            if (cyc !== stb) check("cyc_eq_stb", cyc, stb);
            if (stb) stb_run++;
            else if (stb_run != 0) begin
                last_run = stb_run;
                stb_run  = 0;
            end
            if (stb && !noack) begin
                if (wcnt >= ack_wait) begin
                    wcnt = 0;
                    if (cyc_idx == err_word) begin
                        err = 1'b1;
                        ack = err_both;
                    end else ack = 1'b1;
                    dat_i = rd_word(cur_vec, cyc_idx, adr);
                    cyc_idx++;
                    if (wb_chk) begin
                        if (wb_q.size() == 0) check("wb_extra_cycle", {we, adr}, 0);
                        else begin
                            op = wb_q.pop_front();
                            check("wb_we", we, op.we);
                            check("wb_adr", adr, op.adr);
                            check("wb_sel", sel, 4'hF);
                            if (op.we) check("wb_dat", dat_o, op.dat);
                        end
                    end
                end else wcnt++;
            end
            if (o_tvalid) begin
                if (hold && {o_tlast, o_tdata} !== held) check("out_stable", {o_tlast, o_tdata}, held);
                if (o_tready) begin
                    hold = 0;
                    if (exp_q.size() == 0) check("resp_extra", {1'b1, o_tlast, o_tdata}, 0);
                    else check("resp_byte", {o_tlast, o_tdata}, exp_q.pop_front());
                end else begin
                    hold = 1;
                    held = {o_tlast, o_tdata};
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic l);
        int n = 0;
        @(negedge clk);
        i_tdata  = b;
        i_tvalid = 1'b1;
        i_tlast  = l;
        while (!i_axis_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic run_vec(input int v);
        vec_t        r;
        logic [7:0]  fr[$];
        logic [31:0] a, d;
        bit          bad, stop;
        int          n;
        r        = vt[v];
        cur_vec  = v;
        err_word = r.err_word;
        err_both = r.err_both;
        noack    = r.noack;
        ack_wait = r.ack_wait;
        tr_mode  = r.tr_mode;
        cyc_idx  = 0;
        wcnt     = 0;
        last_run = 0;
        stop     = 0;
        bad      = (r.cmd[7:3] != 0) || !(r.cmd[1:0] inside {2'b01, 2'b10});
        fr.push_back(r.cmd);
        if (bad) begin
            for (int k = 0; k < r.junk; k++) fr.push_back(8'($urandom));
        end else begin
            for (int k = 3; k >= 0; k--) fr.push_back(r.addr[k*8 +: 8]);
            fr.push_back(r.len);
            for (int i = 0; i <= int'(r.len); i++) begin
                a = r.addr + (r.cmd[2] ? 32'd0 : 32'(4 * i));
                if (r.cmd[1]) begin
                    d = $urandom;
                    for (int k = 3; k >= 0; k--) fr.push_back(d[k*8 +: 8]);
                    if (!stop && !r.noack) begin
                        wb_q.push_back('{1'b1, a, d});
                        if (i == r.err_word) stop = 1;
                    end
                end else if (!stop && !r.noack) begin
                    wb_q.push_back('{1'b0, a, 32'd0});
                    if (i == r.err_word) stop = 1;
                    else begin
                        d = rd_word(v, i, a);
                        for (int k = 3; k >= 0; k--) exp_q.push_back({1'b0, d[k*8 +: 8]});
                    end
                end
            end
        end
        exp_q.push_back({1'b1, r.exp_status});
        for (int k = 0; k < fr.size(); k++) send(fr[k], k == fr.size() - 1);
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_done", v), n < 3000, 1);
        check($sformatf("v%0d_resp_left", v), exp_q.size(), 0);
        check($sformatf("v%0d_wb_left", v), wb_q.size(), 0);
        if (r.noack) check($sformatf("v%0d_stb_cycles", v), last_run, 16);
        exp_q.delete();
        wb_q.delete();
    endtask

    initial begin
        //          cmd    addr          len   errw bo na aw tr jk status
        vt[0]  = '{8'h02, 32'h0000_0010, 8'd1, -1, 0, 0, 0, 0, 0, 8'h00};
        vt[1]  = '{8'h05, 32'h0000_0020, 8'd2, -1, 0, 0, 1, 0, 0, 8'h00};
        vt[2]  = '{8'h01, 32'h0000_0000, 8'd0, -1, 0, 1, 0, 0, 0, 8'h02};
        vt[3]  = '{8'h02, 32'h0000_0100, 8'd2,  1, 0, 0, 0, 0, 0, 8'h01};
        vt[4]  = '{8'h01, 32'h0000_0040, 8'd0, -1, 0, 0, 0, 0, 0, 8'h00};
        vt[5]  = '{8'hFF, 32'h0000_0000, 8'd0, -1, 0, 0, 0, 0, 4, 8'h03};
        vt[6]  = '{8'h01, 32'hFFFF_FFFC, 8'd1, -1, 0, 0, 0, 0, 0, 8'h00};
        vt[7]  = '{8'h06, 32'h0000_0008, 8'd2, -1, 0, 0, 3, 0, 0, 8'h00};
        vt[8]  = '{8'h01, 32'h0000_0080, 8'd3,  2, 0, 0, 0, 0, 0, 8'h01};
        vt[9]  = '{8'h02, 32'h0000_0000, 8'd0,  0, 1, 0, 0, 0, 0, 8'h01};
        vt[10] = '{8'h01, 32'h0000_0030, 8'd2, -1, 0, 0, 0, 1, 0, 8'h00};
        vt[11] = '{8'h02, 32'h0000_0200, 8'd1, -1, 0, 1, 0, 0, 0, 8'h02};
        vt[12] = '{8'h03, 32'h0000_0000, 8'd0, -1, 0, 0, 0, 0, 0, 8'h03};
        vt[13] = '{8'h01, 32'h0000_0060, 8'd0, -1, 0, 0, 2, 0, 0, 8'h00};

        i_reset  = 1'b1;
        i_tdata  = '0;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;
        dat_i    = '0;
        ack      = 1'b0;
        err      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tready", i_axis_tready, 0);
        check("rst_tvalid", o_tvalid, 0);
        check("rst_stb", stb, 0);
        check("rst_busy", busy, 0);
        check("rst_adr", adr, 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_tready_rise", i_axis_tready, 1);

        for (int v = 0; v < 13; v++) run_vec(v);

        // reset in the middle of a read burst whose first word is stalled on the output
        tr_mode  = 2;
        wb_chk   = 0;
        noack    = 0;
        err_word = -1;
        ack_wait = 0;
        cyc_idx  = 0;
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h50, 1'b0);
        send(8'h03, 1'b1);
        repeat (6) @(negedge clk);
        check("midrst_pre_tvalid", o_tvalid, 1);
        i_reset = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", o_tvalid, 0);
        check("midrst_stb", stb, 0);
        check("midrst_busy", busy, 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("midrst_tready", i_axis_tready, 1);
        check("midrst_no_status", o_tvalid, 0);
        exp_q.delete();
        wb_q.delete();
        wb_chk = 1;
        run_vec(13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
